mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have inputs EX_MEM_alu_out[31:0], EX_MEM_dataB[31:0], EX_MEM_rd[4:0], EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_write, EX_MEM_mem_read: the EX/MEM pipeline register contents.
REQ-004 SHALL have outputs dmem_req, dmem_we, dmem_addr[31:0], dmem_wdata[31:0] and inputs dmem_rdata[31:0], dmem_ready: data-memory request/ready port.
REQ-005 SHALL have output mem_stall, 1 bit: freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-006 SHALL have outputs MEM_WB_alu_out[31:0], MEM_WB_rdata[31:0], MEM_WB_rd[4:0], MEM_WB_mem_to_reg, MEM_WB_reg_write: the MEM/WB register.
REQ-007 SHALL have output wb_data[31:0]: write-back value, also the EX forward source for select 2'b01.
REQ-008 SHALL have output mem_err, 1 bit: access-timeout pulse, present only per REQ-024.

Function
REQ-009 SHALL treat the current cycle as an access when EX_MEM_mem_read or EX_MEM_mem_write is high.
REQ-010 SHALL let EX_MEM_mem_write take priority when both are high: the access is a store, and the load data is 0.
REQ-011 SHALL drive dmem_addr = {EX_MEM_alu_out[31:2], 2'b00} (word access only), dmem_wdata = EX_MEM_dataB, and dmem_we = EX_MEM_mem_write.
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-013 In IDLE with an access: SHALL assert dmem_req combinationally; if dmem_ready is high the same cycle, the access completes with zero wait and the FSM stays IDLE; otherwise the FSM goes to BUSY.
REQ-014 In BUSY: SHALL hold dmem_req high with stable address, write data and we, and keep mem_stall high; on dmem_ready the access completes, mem_stall drops that cycle, and the FSM returns to IDLE.
REQ-015 SHALL assert mem_stall = access AND NOT completing-this-cycle, so a zero-wait access never stalls.
REQ-016 SHALL keep dmem_req low in IDLE with no access, and SHALL ignore dmem_ready in that case.
REQ-017 Each clock while mem_stall is low, SHALL load the MEM/WB register from the EX_MEM inputs and load MEM_WB_rdata from dmem_rdata (0 for non-loads).
REQ-018 Each clock while mem_stall is high, SHALL load a bubble: MEM_WB_reg_write = 0, all other MEM/WB fields hold.
REQ-019 SHALL compute wb_data = MEM_WB_mem_to_reg ? MEM_WB_rdata : MEM_WB_alu_out, combinationally.
REQ-020 Latency: a load completing in cycle N SHALL appear on wb_data in cycle N+1.
REQ-021 Back-to-back accesses SHALL each issue exactly one request, with no duplicate issue after completion.

Reset
REQ-022 While reset is high at a clock edge, SHALL set the FSM to IDLE, clear all MEM/WB fields to 0, and clear the timeout counter.
REQ-023 Reset asserted mid-BUSY SHALL abandon the access: dmem_req and mem_stall are 0 in the cycle after the edge; a late dmem_ready is ignored.

Configuration
REQ-024 SHALL honour macro MEM_TIMEOUT_EN.
- Defined: a 4-bit counter increments in each BUSY cycle. If BUSY reaches 15 cycles without dmem_ready, the access aborts: FSM goes to IDLE, mem_stall drops, mem_err pulses high for 1 cycle, and MEM/WB loads reg_write = 0. The counter clears on entry to BUSY.
- Undefined: BUSY waits indefinitely; no counter; mem_err tied to 0.

Verification
REQ-025 SHALL pass: load, alu_out=0x0000_0106, dmem_ready already high -> dmem_addr=0x104, no stall; next cycle wb_data=dmem_rdata.
REQ-026 SHALL pass: store, dataB=0xDEAD_BEEF, ready after 3 cycles -> mem_stall high for exactly 3 cycles; dmem_we/addr/wdata stable throughout; MEM_WB_reg_write=0 for those 3 clocks.
REQ-027 SHALL pass: two back-to-back loads with 1 wait each -> exactly 2 dmem_req completions, correct rd/rdata pairing in MEM/WB.
REQ-028 SHALL pass: reset asserted in the 2nd BUSY cycle, then ready -> FSM IDLE, MEM_WB all zero, no write-back.
REQ-029 SHALL pass: mem_read and mem_write both high -> dmem_we=1; MEM_WB_rdata=0.
REQ-030 SHALL pass (with MEM_TIMEOUT_EN): ready never asserted -> stall for 15 cycles, then mem_err=1 for 1 cycle and MEM_WB_reg_write=0.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory request/ready handshake (IDLE/BUSY FSM) and the MEM/WB register.
// Optional access timeout is compiled in when MEM_TIMEOUT_EN is defined.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] EX_MEM_alu_out,
  input  logic [31:0] EX_MEM_dataB,
  input  logic [4:0]  EX_MEM_rd,
  input  logic        EX_MEM_mem_to_reg,
  input  logic        EX_MEM_reg_write,
  input  logic        EX_MEM_mem_write,
  input  logic        EX_MEM_mem_read,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic [31:0] MEM_WB_alu_out,
  output logic [31:0] MEM_WB_rdata,
  output logic [4:0]  MEM_WB_rd,
  output logic        MEM_WB_mem_to_reg,
  output logic        MEM_WB_reg_write,
  output logic [31:0] wb_data,
  output logic        mem_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_reg, state_next;
  logic   access;
  logic   is_load;
  logic   active;
  logic   timeout;

  assign access  = EX_MEM_mem_read | EX_MEM_mem_write;
  assign is_load = EX_MEM_mem_read & ~EX_MEM_mem_write;
  // Gating with reset lets an abandoned access disappear as soon as reset is seen.
  assign active  = ~reset & (access | (state_reg == BUSY));

`ifdef MEM_TIMEOUT_EN
  logic [3:0] timer_reg, timer_next;

  // Counts BUSY cycles; forced to 0 outside BUSY so every new wait starts fresh.
  always_comb begin
    timer_next = 4'd0;
    if (state_reg == BUSY) timer_next = timer_reg + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) timer_reg <= 4'd0;
    else       timer_reg <= timer_next;
  end

  // The 15th BUSY cycle without ready gives up instead of stalling again.
  assign timeout = active & (state_reg == BUSY) & (timer_reg == 4'd14) & ~dmem_ready;
  assign mem_err = timeout;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  assign dmem_req   = active & ~timeout;
  assign mem_stall  = active & ~dmem_ready & ~timeout;
  assign dmem_we    = EX_MEM_mem_write;
  assign dmem_addr  = {EX_MEM_alu_out[31:2], 2'b00};
  assign dmem_wdata = EX_MEM_dataB;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (mem_stall)  state_next = BUSY;
      BUSY:    if (!mem_stall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A stalled cycle inserts a bubble: only reg_write is cleared, the rest holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      MEM_WB_alu_out    <= 32'd0;
      MEM_WB_rdata      <= 32'd0;
      MEM_WB_rd         <= 5'd0;
      MEM_WB_mem_to_reg <= 1'b0;
      MEM_WB_reg_write  <= 1'b0;
    end else if (mem_stall) begin
      MEM_WB_reg_write  <= 1'b0;
    end else begin
      MEM_WB_alu_out    <= EX_MEM_alu_out;
      MEM_WB_rdata      <= (is_load && !timeout) ? dmem_rdata : 32'd0;
      MEM_WB_rd         <= EX_MEM_rd;
      MEM_WB_mem_to_reg <= EX_MEM_mem_to_reg;
      MEM_WB_reg_write  <= EX_MEM_reg_write & ~timeout;
    end
  end

  assign wb_data = MEM_WB_mem_to_reg ? MEM_WB_rdata : MEM_WB_alu_out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus random transactions
// scored against a cycle-level behavioural model of the MEM stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] EX_MEM_alu_out, EX_MEM_dataB;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_mem_to_reg, EX_MEM_reg_write, EX_MEM_mem_write, EX_MEM_mem_read;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        mem_stall;
  logic [31:0] MEM_WB_alu_out, MEM_WB_rdata;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_mem_to_reg, MEM_WB_reg_write;
  logic [31:0] wb_data;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  // Expected MEM/WB contents after the most recent clock edge.
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_rd;
  logic        m_m2r, m_rw;
  bit          m_valid = 1'b0;
  int          stall_run = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .EX_MEM_alu_out(EX_MEM_alu_out), .EX_MEM_dataB(EX_MEM_dataB), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_mem_to_reg(EX_MEM_mem_to_reg), .EX_MEM_reg_write(EX_MEM_reg_write),
    .EX_MEM_mem_write(EX_MEM_mem_write), .EX_MEM_mem_read(EX_MEM_mem_read),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .mem_stall(mem_stall),
    .MEM_WB_alu_out(MEM_WB_alu_out), .MEM_WB_rdata(MEM_WB_rdata), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_mem_to_reg(MEM_WB_mem_to_reg), .MEM_WB_reg_write(MEM_WB_reg_write),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  // One clock of stimulus: checks the registered state left by the previous edge,
  // applies new inputs, checks the combinational response, then advances the model.
  task automatic cycle(input logic rst, input logic rd_en, input logic wr_en,
                       input logic [31:0] alu, input logic [31:0] db, input logic [4:0] rd,
                       input logic m2r, input logic rw, input logic ready,
                       input logic [31:0] rdata, input string tag);
    logic        acc, abort, exp_stall, exp_req;
    logic [31:0] exp_wb;
    @(negedge clk);
    if (m_valid) begin
      exp_wb = m_m2r ? m_rdata : m_alu;
      checks++; if (MEM_WB_alu_out !== m_alu) begin errors++; $display("FAIL %s MEM_WB_alu_out: got %h expected %h", tag, MEM_WB_alu_out, m_alu); end
      checks++; if (MEM_WB_rdata !== m_rdata) begin errors++; $display("FAIL %s MEM_WB_rdata: got %h expected %h", tag, MEM_WB_rdata, m_rdata); end
      checks++; if (MEM_WB_rd !== m_rd) begin errors++; $display("FAIL %s MEM_WB_rd: got %0d expected %0d", tag, MEM_WB_rd, m_rd); end
      checks++; if (MEM_WB_mem_to_reg !== m_m2r) begin errors++; $display("FAIL %s MEM_WB_mem_to_reg: got %b expected %b", tag, MEM_WB_mem_to_reg, m_m2r); end
      checks++; if (MEM_WB_reg_write !== m_rw) begin errors++; $display("FAIL %s MEM_WB_reg_write: got %b expected %b", tag, MEM_WB_reg_write, m_rw); end
      checks++; if (wb_data !== exp_wb) begin errors++; $display("FAIL %s wb_data: got %h expected %h", tag, wb_data, exp_wb); end
    end
    reset = rst;
    EX_MEM_mem_read = rd_en; EX_MEM_mem_write = wr_en;
    EX_MEM_alu_out = alu; EX_MEM_dataB = db; EX_MEM_rd = rd;
    EX_MEM_mem_to_reg = m2r; EX_MEM_reg_write = rw;
    dmem_ready = ready; dmem_rdata = rdata;
    #1;
    acc   = rd_en | wr_en;
    abort = 1'b0;
`ifdef MEM_TIMEOUT_EN
    abort = acc && !ready && (stall_run == 15);
`endif
    exp_stall = acc && !ready && !abort;
    exp_req   = acc && !abort;
    if (!rst) begin
      checks++; if (dmem_req !== exp_req) begin errors++; $display("FAIL %s dmem_req: got %b expected %b", tag, dmem_req, exp_req); end
      checks++; if (mem_stall !== exp_stall) begin errors++; $display("FAIL %s mem_stall: got %b expected %b", tag, mem_stall, exp_stall); end
      checks++; if (mem_err !== abort) begin errors++; $display("FAIL %s mem_err: got %b expected %b", tag, mem_err, abort); end
      if (acc) begin
        checks++; if (dmem_addr !== (alu & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s dmem_addr: got %h expected %h", tag, dmem_addr, alu & 32'hFFFF_FFFC); end
        checks++; if (dmem_we !== wr_en) begin errors++; $display("FAIL %s dmem_we: got %b expected %b", tag, dmem_we, wr_en); end
        checks++; if (dmem_wdata !== db) begin errors++; $display("FAIL %s dmem_wdata: got %h expected %h", tag, dmem_wdata, db); end
      end
    end
    if (rst) begin
      m_alu = '0; m_rdata = '0; m_rd = '0; m_m2r = 1'b0; m_rw = 1'b0; stall_run = 0;
    end else if (exp_stall) begin
      m_rw = 1'b0; stall_run++;
    end else begin
      m_alu = alu; m_rd = rd; m_m2r = m2r; m_rw = rw && !abort;
      m_rdata = (rd_en && !wr_en && !abort) ? rdata : 32'd0;
      stall_run = 0;
    end
    m_valid = 1'b1;
  endtask

  // A whole access (or idle slot): memory answers after 'waits' cycles.
  task automatic txn(input logic rd_en, input logic wr_en, input logic [31:0] alu,
                     input logic [31:0] db, input logic [4:0] rd, input logic m2r,
                     input logic rw, input int waits, input logic [31:0] rdata, input string tag);
    for (int c = 0; c <= waits; c++)
      cycle(1'b0, rd_en, wr_en, alu, db, rd, m2r, rw, (c == waits) ? 1'b1 : 1'b0,
            (c == waits) ? rdata : $urandom, tag);
    $display("txn %s: rd=%b wr=%b addr=%h wdata=%h rd#=%0d waits=%0d rdata=%h", tag,
             rd_en, wr_en, alu & 32'hFFFF_FFFC, db, rd, waits, rdata);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'($urandom), $urandom, tag);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, $urandom, $urandom, 5'd7, 1'b1, 1'b1, 1'b0, $urandom, "reset");
    cycle(1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'd9, 1'b1, 1'b1, 1'b1, $urandom, "reset");
    idle("reset_idle");
    $display("txn reset: MEM/WB cleared, no request");
  endtask

  task automatic test_zero_wait_load();
    txn(1'b1, 1'b0, 32'h0000_0106, 32'h1111_2222, 5'd3, 1'b1, 1'b1, 0, 32'hCAFE_0001, "zero_wait_load");
  endtask

  task automatic test_store_wait();
    txn(1'b0, 1'b1, 32'h0000_0A08, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 3, 32'h0, "store_wait3");
    idle("after_store");
  endtask

  task automatic test_back_to_back();
    txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 5'd5, 1'b1, 1'b1, 1, 32'hAAAA_0005, "b2b_load_a");
    txn(1'b1, 1'b0, 32'h0000_0204, 32'h0, 5'd6, 1'b1, 1'b1, 1, 32'hBBBB_0006, "b2b_load_b");
    idle("after_b2b");
  endtask

  task automatic test_read_write_both();
    txn(1'b1, 1'b1, 32'h0000_0310, 32'h1234_5678, 5'd8, 1'b1, 1'b1, 1, 32'hFFFF_FFFF, "rd_wr_both");
    idle("after_both");
  endtask

  task automatic test_reset_mid_busy();
    txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 5'd10, 1'b1, 1'b1, 0, 32'h5555_AAAA, "pre_reset_load");
    cycle(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, $urandom, "busy_entry");
    cycle(1'b0, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, $urandom, "busy_1");
    cycle(1'b1, 1'b1, 1'b0, 32'h0000_0404, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, $urandom, "busy_2_reset");
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h7777_7777, "late_ready");
    idle("post_reset");
    $display("txn reset_mid_busy: access abandoned, late ready ignored");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int kind = $urandom_range(0, 3);
      txn((kind == 1 || kind == 3) ? 1'b1 : 1'b0, (kind >= 2) ? 1'b1 : 1'b0,
          $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
          (kind == 0) ? 0 : $urandom_range(0, 3), $urandom, $sformatf("rand%0d", i));
    end
    idle("after_random");
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    for (int c = 0; c < 16; c++)
      cycle(1'b0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 5'd12, 1'b1, 1'b1, 1'b0, $urandom, $sformatf("timeout_c%0d", c));
    idle("after_timeout");
    $display("txn timeout: 15 stall cycles then abort with mem_err");
  endtask
`endif

  initial begin
    reset = 1'b1;
    EX_MEM_alu_out = '0; EX_MEM_dataB = '0; EX_MEM_rd = '0;
    EX_MEM_mem_to_reg = 1'b0; EX_MEM_reg_write = 1'b0;
    EX_MEM_mem_write = 1'b0; EX_MEM_mem_read = 1'b0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    m_alu = '0; m_rdata = '0; m_rd = '0; m_m2r = 1'b0; m_rw = 1'b0;
    test_reset();
    test_zero_wait_load();
    test_store_wait();
    test_back_to_back();
    test_read_write_both();
    test_reset_mid_busy();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    idle("final");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
